// File: rtl/dfx_ma_pkg.sv
// dfx_ma_pkg: shared types, default widths and round-robin helper
// for the DFX memory write arbiter.
package dfx_ma_pkg;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_ADDRWIDTH = 10;
  localparam int DEF_DATAWIDTH = 1024;
  localparam int IDWIDTH       = $clog2(DEF_NUM_REQ);

  typedef logic [IDWIDTH-1:0] idx_t;

  function automatic int unsigned rr_next(
    input int unsigned p,
    input int unsigned n
  );
    return (p == n - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/dfx_wr_arbiter_if.sv
// dfx_wr_arbiter_if: requester channels plus the shared memory
// write port of the DFX write arbiter.
interface dfx_wr_arbiter_if
  import dfx_ma_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int ADDRWIDTH = DEF_ADDRWIDTH,
  parameter int DATAWIDTH = DEF_DATAWIDTH
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]           wr_req;
  logic [NUM_REQ-1:0]           wr_gnt;
  logic [NUM_REQ*ADDRWIDTH-1:0] wr_addr;
  logic [NUM_REQ*DATAWIDTH-1:0] wr_data;
  logic                         mem_valid;
  logic                         mem_ready;
  logic [ADDRWIDTH-1:0]         mem_addr;
  logic [DATAWIDTH-1:0]         mem_data;
  logic [IDW-1:0]               mem_src;
  logic                         busy_o;

  modport master (
    input  wr_req, wr_addr, wr_data, mem_ready,
    output wr_gnt, mem_valid, mem_addr, mem_data,
    output mem_src, busy_o
  );

  modport slave (
    output wr_req, wr_addr, wr_data, mem_ready,
    input  wr_gnt, mem_valid, mem_addr, mem_data,
    input  mem_src, busy_o
  );

endinterface

// File: rtl/dfx_rr_picker.sv
// dfx_rr_picker: combinational round-robin selector; searches req
// upward from ptr with wrap and returns a one-hot grant and its index.
module dfx_rr_picker #(
  parameter int NUM_REQ = 4,
  localparam int IDW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     idx,
  output logic               any
);

  logic [IDW:0]   s;
  logic [IDW-1:0] j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    s   = '0;
    j   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      s = {1'b0, ptr} + (IDW+1)'(k);
      if (s >= (IDW+1)'(NUM_REQ))
        s = s - (IDW+1)'(NUM_REQ);
      j = s[IDW-1:0];
      if (en && !any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/dfx_wr_arbiter.sv
// dfx_wr_arbiter: round-robin merge of NUM_REQ write channels onto
// one memory write port through a one-entry valid/ready register.
module dfx_wr_arbiter
  import dfx_ma_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int ADDRWIDTH = DEF_ADDRWIDTH,
  parameter int DATAWIDTH = DEF_DATAWIDTH
) (
  input logic               clk,
  input logic               rst_n,
  dfx_wr_arbiter_if.master  bus
);

  localparam int IDW = $clog2(NUM_REQ);

  logic                 accept;
  logic                 any;
  logic [NUM_REQ-1:0]   gnt;
  logic [IDW-1:0]       idx;
  logic [IDW-1:0]       ptr;
  logic                 valid_q;
  logic [ADDRWIDTH-1:0] addr_q;
  logic [ADDRWIDTH-1:0] addr_mux;
  logic [DATAWIDTH-1:0] data_q;
  logic [DATAWIDTH-1:0] data_mux;
  logic [IDW-1:0]       src_q;

  // rst_n gates the grant so wr_gnt is zero throughout reset
  assign accept = !valid_q || bus.mem_ready;

  dfx_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req (bus.wr_req),
    .ptr (ptr),
    .en  (accept && rst_n),
    .gnt (gnt),
    .idx (idx),
    .any (any)
  );

  always_comb begin
    addr_mux = '0;
    data_mux = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_mux = addr_mux |
        (bus.wr_addr[i*ADDRWIDTH +: ADDRWIDTH] & {ADDRWIDTH{gnt[i]}});
      data_mux = data_mux |
        (bus.wr_data[i*DATAWIDTH +: DATAWIDTH] & {DATAWIDTH{gnt[i]}});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      src_q   <= '0;
    end else if (any) begin
      ptr     <= IDW'(rr_next(32'(idx), NUM_REQ));
      valid_q <= 1'b1;
      addr_q  <= addr_mux;
      data_q  <= data_mux;
      src_q   <= idx;
    end else if (bus.mem_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.wr_gnt    = gnt;
  assign bus.mem_valid = valid_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_data  = data_q;
  assign bus.mem_src   = src_q;
  assign bus.busy_o    = valid_q || (|bus.wr_req);

endmodule

// File: tb/tb_dfx_wr_arbiter.sv
// tb_dfx_wr_arbiter: directed checks of grant order, backpressure,
// wrap-around, output isolation and asynchronous reset.
module tb_dfx_wr_arbiter;
  import dfx_ma_pkg::*;

  localparam int N  = DEF_NUM_REQ;
  localparam int AW = DEF_ADDRWIDTH;
  localparam int DW = DEF_DATAWIDTH;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  dfx_wr_arbiter_if #(
    .NUM_REQ   (N),
    .ADDRWIDTH (AW),
    .DATAWIDTH (DW)
  ) bus ();

  dfx_wr_arbiter #(
    .NUM_REQ   (N),
    .ADDRWIDTH (AW),
    .DATAWIDTH (DW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [AW-1:0] apat(int ch, int seq);
    return AW'(ch * 64 + seq);
  endfunction

  function automatic logic [DW-1:0] dpat(int ch, int seq);
    return {32{32'hA500_0000 + 32'(seq * 256 + ch * 16)}};
  endfunction

  task automatic load(int seq);
    for (int c = 0; c < N; c++) begin
      bus.wr_addr[c*AW +: AW] = apat(c, seq);
      bus.wr_data[c*DW +: DW] = dpat(c, seq);
    end
  endtask

  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h (low 64b)",
             tag, obs[63:0], exp[63:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(string tag, logic v, int src, int seq);
    chk({tag, ".valid"}, DW'(bus.mem_valid), DW'(v));
    chk({tag, ".src"}, DW'(bus.mem_src), DW'(src));
    chk({tag, ".addr"}, DW'(bus.mem_addr), DW'(apat(src, seq)));
    chk({tag, ".data"}, bus.mem_data, dpat(src, seq));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.wr_req    = '0;
    bus.mem_ready = 1'b0;
    load(1);
    tick();
    #1;
    chk("rst.gnt", DW'(bus.wr_gnt), '0);
    chk("rst.valid", DW'(bus.mem_valid), '0);
    chk("rst.addr", DW'(bus.mem_addr), '0);
    chk("rst.data", bus.mem_data, '0);
    chk("rst.src", DW'(bus.mem_src), '0);
    chk("rst.busy", DW'(bus.busy_o), '0);
    tick();
    rst_n = 1'b1;

    // 1: single request on channel 0
    bus.wr_req    = 4'b0001;
    bus.mem_ready = 1'b1;
    #1;
    chk("t1.gnt", DW'(bus.wr_gnt), DW'(4'b0001));
    chk("t1.busy", DW'(bus.busy_o), DW'(1'b1));
    tick();
    bus.wr_req = '0;
    #1;
    chk_out("t1.out", 1'b1, 0, 1);
    chk("t1.gnt_off", DW'(bus.wr_gnt), '0);
    tick();
    chk("t1.drain", DW'(bus.mem_valid), '0);

    // 2: all requesting, full throughput
    do_reset();
    load(2);
    bus.wr_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("t2.gnt%0d", k), DW'(bus.wr_gnt),
          DW'(4'b0001 << (k % 4)));
      tick();
      chk_out($sformatf("t2.out%0d", k), 1'b1, k % 4, 2);
    end

    // 3: backpressure holds the register and blocks grants
    bus.mem_ready = 1'b0;
    #1;
    chk("t3.gnt_blk", DW'(bus.wr_gnt), '0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("t3.gnt%0d", k), DW'(bus.wr_gnt), '0);
      chk_out($sformatf("t3.hold%0d", k), 1'b1, 0, 2);
    end
    bus.mem_ready = 1'b1;
    #1;
    chk("t3.gnt_rel", DW'(bus.wr_gnt), DW'(4'b0010));
    tick();
    bus.wr_req = '0;
    chk_out("t3.out", 1'b1, 1, 2);
    tick();
    chk("t3.drain", DW'(bus.mem_valid), '0);

    // 4: pointer wrap from 3 to channel 0
    load(4);
    bus.wr_req = 4'b0100;
    #1;
    chk("t4.gnt2", DW'(bus.wr_gnt), DW'(4'b0100));
    tick();
    bus.wr_req = 4'b0011;
    #1;
    chk("t4.gnt0", DW'(bus.wr_gnt), DW'(4'b0001));
    tick();
    chk_out("t4.out0", 1'b1, 0, 4);
    #1;
    chk("t4.gnt1", DW'(bus.wr_gnt), DW'(4'b0010));
    tick();
    bus.wr_req = '0;
    chk_out("t4.out1", 1'b1, 1, 4);
    tick();

    // 5: output carries only the granted channel
    for (int c = 0; c < N; c++) begin
      bus.wr_addr[c*AW +: AW] = (c == 3) ? '1 : apat(c, 5);
      bus.wr_data[c*DW +: DW] = (c == 3) ? '1 : dpat(c, 5);
    end
    bus.wr_req = 4'b1000;
    #1;
    chk("t5.gnt", DW'(bus.wr_gnt), DW'(4'b1000));
    tick();
    chk("t5.addr1", DW'(bus.mem_addr), DW'(10'h3FF));
    chk("t5.data1", bus.mem_data, '1);
    for (int c = 0; c < N; c++) begin
      bus.wr_addr[c*AW +: AW] = (c == 3) ? '0 : '1;
      bus.wr_data[c*DW +: DW] = (c == 3) ? '0 : '1;
    end
    #1;
    chk("t5.regnt", DW'(bus.wr_gnt), DW'(4'b1000));
    tick();
    bus.wr_req = '0;
    chk("t5.addr0", DW'(bus.mem_addr), '0);
    chk("t5.data0", bus.mem_data, '0);
    chk("t5.src", DW'(bus.mem_src), DW'(idx_t'(3)));
    tick();

    // 6: async reset with a stalled write pending
    load(6);
    bus.wr_req    = 4'b0001;
    bus.mem_ready = 1'b0;
    #1;
    chk("t6.gnt", DW'(bus.wr_gnt), DW'(4'b0001));
    tick();
    bus.wr_req = '0;
    tick();
    chk("t6.stall", DW'(bus.mem_valid), DW'(1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6.valid", DW'(bus.mem_valid), '0);
    chk("t6.addr", DW'(bus.mem_addr), '0);
    chk("t6.data", bus.mem_data, '0);
    chk("t6.src", DW'(bus.mem_src), '0);
    chk("t6.busy", DW'(bus.busy_o), '0);
    bus.wr_req = 4'b1111;
    #1;
    chk("t6.gnt_rst", DW'(bus.wr_gnt), '0);
    bus.wr_req = '0;
    tick();
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    bus.wr_req    = 4'b0110;
    #1;
    chk("t6.first", DW'(bus.wr_gnt), DW'(4'b0010));
    tick();
    bus.wr_req = '0;
    chk_out("t6.out", 1'b1, 1, 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
